aes_load_arbiter: RTL and testbench
===================================

AES_LOAD_ARBITER -- requirements
Module: aes_load_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, input word width.
REQ-002 SHALL have parameter N_WORDS, default 4, words per block; block width BLK_W = WORD_W*N_WORDS (128).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port key_valid, input, 1, key word offered.
REQ-006 SHALL have port key_word, input, WORD_W, key word.
REQ-007 SHALL have port key_ready, output, 1, key word accepted this cycle when key_valid is also high.
REQ-008 SHALL have ports data_valid (input, 1), data_word (input, WORD_W) and data_ready (output, 1), plaintext port with the same semantics as the key port.
REQ-009 SHALL have port blk_valid, output, 1, assembled block available.
REQ-010 SHALL have port blk_ready, input, 1, downstream accepts block.
REQ-011 SHALL have port blk_data, output, BLK_W, assembled block.
REQ-012 SHALL have port blk_is_key, output, 1, 1 = block came from key port.
REQ-013 SHALL have port busy, output, 1, high in LOAD or HOLD.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD and HOLD.
REQ-015 In IDLE, SHALL arbitrate among valid ports; if only one is valid it wins.
REQ-016 If both ports are valid in IDLE, SHALL grant the port not granted last (round-robin).
REQ-017 In IDLE, SHALL assert ready combinationally to the winner only; that word is accepted the same cycle, grant is latched, and the FSM goes to LOAD with count 1.
REQ-018 In LOAD, SHALL hold ready high only on the granted port; the other port's ready stays 0 and its valid is ignored (no interleaving).
REQ-019 On each accept, SHALL shift the block register as {blk[BLK_W-WORD_W-1:0], word}; the first word ends in bits [127:96].
REQ-020 If granted valid is low in LOAD, SHALL hold count and contents with no timeout.
REQ-021 On accept of word N_WORDS, SHALL go to HOLD; blk_valid rises the next cycle, and blk_is_key reflects the grant.
REQ-022 In HOLD, SHALL keep both readies at 0 and hold blk_data/blk_is_key stable until handshake.
REQ-023 On blk_valid&&blk_ready, SHALL go to IDLE, drop blk_valid next cycle and update last-grant; minimum period with blk_ready held high is N_WORDS+1 cycles per block.
REQ-024 SHALL ignore blk_ready while blk_valid is low.
REQ-025 The word counter SHALL be $clog2(N_WORDS+1) bits and wrap to 0 on leaving HOLD.

Reset
REQ-026 rst SHALL force IDLE, count 0, block register 0, blk_valid 0, blk_is_key 0, busy 0 and last-grant = DATA (key wins first tie).
REQ-027 rst mid-LOAD or mid-HOLD SHALL discard the partial or unaccepted block; no blk_valid follows.
REQ-028 key_ready and data_ready SHALL be 0 during reset.

Structure
REQ-029 Package aes_pkg SHALL hold the state enum, the grant enum (SRC_KEY, SRC_DATA), WORD_W_DEF=32 and N_WORDS_DEF=4.
REQ-030 The block register SHALL be sub-module word_shift_reg_128, a WORD_W-to-BLK_W shifter with shift enable, asynchronous rst, and no shift without enable.
REQ-031 Arbitration, counter and FSM SHALL reside in aes_load_arbiter.

Verification
REQ-032 Key-only stream: key words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F back-to-back with blk_ready=1 -> blk_data=0x000102030405060708090A0B0C0D0E0F, blk_is_key=1, blk_valid 1 cycle after 4th accept.
REQ-033 Both valid continuously after reset -> blocks alternate key, data, key, data; no word of one port appears in the other's block.
REQ-034 Backpressure: blk_ready=0 for 10 cycles in HOLD -> blk_data stable, both readies 0, no words consumed; single handshake on blk_ready=1.
REQ-035 Valid gaps: data_valid low for 3 cycles after word 2 -> count held, block correct after words 3-4, blk_is_key=0.
REQ-036 rst pulse after 2 words accepted -> all outputs at reset values; the next 4 words form a clean block with no stale bits.
REQ-037 Throughput: both ports valid, blk_ready=1 -> exactly one block handshake every 5 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and defaults for the AES block loader: FSM states, source
// (grant) encoding and default word/block geometry.
package aes_pkg;

  localparam int WORD_W_DEF  = 32;
  localparam int N_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic {
    SRC_KEY  = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

endpackage

// File: rtl/word_shift_reg_128.sv
// Word-to-block shift register: each enabled cycle shifts one word in at the
// bottom, so the first word loaded ends up in the most significant slot.
module word_shift_reg_128
  import aes_pkg::*;
#(
  parameter int  WORD_W  = WORD_W_DEF,
  parameter int  N_WORDS = N_WORDS_DEF,
  localparam int BLK_W   = WORD_W * N_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [BLK_W-1:0]  blk_o
);

  logic [BLK_W-1:0] blk_q;
  logic [BLK_W-1:0] blk_d;

  always_comb begin
    if (shift_en_i) begin
      blk_d = {blk_q[BLK_W-WORD_W-1:0], word_i};
    end else begin
      blk_d = blk_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q <= '0;
    end else begin
      blk_q <= blk_d;
    end
  end

  assign blk_o = blk_q;

endmodule

// File: rtl/aes_load_arbiter.sv
// Round-robin loader: collects N_WORDS words from either the key or the data
// port into one block, never interleaving the two sources within a block.
module aes_load_arbiter
  import aes_pkg::*;
#(
  parameter int  WORD_W  = WORD_W_DEF,
  parameter int  N_WORDS = N_WORDS_DEF,
  localparam int BLK_W   = WORD_W * N_WORDS,
  localparam int CNT_W   = $clog2(N_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [WORD_W-1:0] key_word,
  output logic              key_ready,
  input  logic              data_valid,
  input  logic [WORD_W-1:0] data_word,
  output logic              data_ready,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [BLK_W-1:0]  blk_data,
  output logic              blk_is_key,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_WORDS);

  state_e            state_q;
  src_e              grant_q;
  src_e              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              blk_valid_q;
  logic              blk_is_key_q;
  logic              busy_q;

  src_e              win_s;
  src_e              src_s;
  logic              key_rdy_s;
  logic              data_rdy_s;
  logic              accept_s;
  logic [WORD_W-1:0] word_s;

  // Arbitration: a tie in IDLE goes to the port that lost the previous block.
  always_comb begin
    win_s      = SRC_KEY;
    key_rdy_s  = 1'b0;
    data_rdy_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid && data_valid) begin
          win_s = (last_q == SRC_DATA) ? SRC_KEY : SRC_DATA;
        end else if (data_valid) begin
          win_s = SRC_DATA;
        end else begin
          win_s = SRC_KEY;
        end
        key_rdy_s  = key_valid && (win_s == SRC_KEY);
        data_rdy_s = data_valid && (win_s == SRC_DATA);
      end
      LOAD: begin
        key_rdy_s  = (grant_q == SRC_KEY);
        data_rdy_s = (grant_q == SRC_DATA);
      end
      HOLD: begin
        key_rdy_s  = 1'b0;
        data_rdy_s = 1'b0;
      end
      default: begin
        key_rdy_s  = 1'b0;
        data_rdy_s = 1'b0;
      end
    endcase
    src_s    = (state_q == IDLE) ? win_s : grant_q;
    accept_s = (key_rdy_s && key_valid) || (data_rdy_s && data_valid);
    word_s   = (src_s == SRC_KEY) ? key_word : data_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= SRC_KEY;
      last_q       <= SRC_DATA;
      cnt_q        <= '0;
      blk_valid_q  <= 1'b0;
      blk_is_key_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            grant_q <= src_s;
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (accept_s) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q        <= CNT_FULL;
              blk_valid_q  <= 1'b1;
              blk_is_key_q <= (grant_q == SRC_KEY);
              state_q      <= HOLD;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (blk_valid_q && blk_ready) begin
            cnt_q       <= '0;
            blk_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= grant_q;
            state_q     <= IDLE;
          end
        end
        default: begin
          cnt_q       <= '0;
          blk_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  word_shift_reg_128 #(
    .WORD_W  (WORD_W),
    .N_WORDS (N_WORDS)
  ) u_blk_reg (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (accept_s),
    .word_i     (word_s),
    .blk_o      (blk_data)
  );

  // Readies are combinational, so they must be masked while reset is held.
  assign key_ready  = key_rdy_s && !rst;
  assign data_ready = data_rdy_s && !rst;
  assign blk_valid  = blk_valid_q;
  assign blk_is_key = blk_is_key_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_aes_load_arbiter.sv
// Scoreboard bench for aes_load_arbiter: expected blocks are queued by the
// stimulus, and a negedge monitor pops and compares on every handshake.
module tb_aes_load_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_valid, data_valid, blk_ready;
  logic [31:0]   key_word, data_word;
  logic          key_ready, data_ready, blk_valid, blk_is_key, busy;
  logic [127:0]  blk_data;

  typedef struct {
    logic [127:0] data;
    logic         is_key;
  } exp_t;

  exp_t exp_q[$];
  int   hs_cyc[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_cnt   = 0;
  int   cyc      = 0;

  aes_load_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_word   (key_word),
    .key_ready  (key_ready),
    .data_valid (data_valid),
    .data_word  (data_word),
    .data_ready (data_ready),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .blk_is_key (blk_is_key),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkblk(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3);
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] kw(input int j, input int i);
    return 32'hA000_0000 + 32'(j * 16 + i);
  endfunction

  function automatic logic [31:0] dw(input int j, input int i);
    return 32'hD000_0000 + 32'(j * 16 + i);
  endfunction

  task automatic push_exp(input logic [127:0] d, input logic k);
    exp_t e;
    e.data   = d;
    e.is_key = k;
    exp_q.push_back(e);
  endtask

  // Offer one word and hold it until the DUT takes it (bounded wait).
  task automatic send(input bit k, input logic [31:0] w);
    int n;
    n = 0;
    if (k) begin key_valid = 1'b1; key_word = w; end
    else begin data_valid = 1'b1; data_word = w; end
    @(negedge clk);
    while (!(k ? key_ready : data_ready) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no ready after %0d cycles, expected ready", n);
    end
    @(posedge clk); #1;
    if (k) key_valid = 1'b0;
    else data_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted block is checked against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && blk_valid && blk_ready) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_block: got %h expected no block", blk_data);
      end else begin
        e = exp_q.pop_front();
        chk("blk_data", blk_data, e.data);
        chk("blk_is_key", {127'd0, blk_is_key}, {127'd0, e.is_key});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] held;
    int hs_before;

    // Reset values, with both ports offering to prove readies stay low.
    rst = 1'b1; key_valid = 1'b1; data_valid = 1'b1; blk_ready = 1'b1;
    key_word = 32'h0; data_word = 32'h0;
    #12;
    chk("rst_key_ready", {127'd0, key_ready}, 128'd0);
    chk("rst_data_ready", {127'd0, data_ready}, 128'd0);
    chk("rst_blk_valid", {127'd0, blk_valid}, 128'd0);
    chk("rst_blk_data", blk_data, 128'd0);
    chk("rst_blk_is_key", {127'd0, blk_is_key}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    @(posedge clk); #1;
    key_valid = 1'b0; data_valid = 1'b0;
    rst = 1'b0;
    wait_cyc(1);

    // Key-only stream, back to back.
    push_exp(128'h000102030405060708090A0B0C0D0E0F, 1'b1);
    send(1'b1, 32'h00010203);
    send(1'b1, 32'h04050607);
    send(1'b1, 32'h08090A0B);
    chk("key_stream_valid_early", {127'd0, blk_valid}, 128'd0);
    send(1'b1, 32'h0C0D0E0F);
    chk("key_stream_valid_latency", {127'd0, blk_valid}, 128'd1);
    chk("key_stream_busy", {127'd0, busy}, 128'd1);
    wait_cyc(2);

    // Backpressure in HOLD on a data block.
    blk_ready = 1'b0;
    held = mkblk(dw(9, 0), dw(9, 1), dw(9, 2), dw(9, 3));
    push_exp(held, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b0, dw(9, i));
    key_valid = 1'b1; data_valid = 1'b1; key_word = 32'hDEAD_BEEF; data_word = 32'hBAD0_BAD0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_blk_valid", {127'd0, blk_valid}, 128'd1);
      chk("bp_blk_data", blk_data, held);
      chk("bp_readies", {126'd0, key_ready, data_ready}, 128'd0);
    end
    @(posedge clk); #1;
    key_valid = 1'b0; data_valid = 1'b0;
    hs_before = hs_cnt;
    blk_ready = 1'b1;
    wait_cyc(1);
    chk("bp_valid_drop", {127'd0, blk_valid}, 128'd0);
    chk("bp_busy_drop", {127'd0, busy}, 128'd0);
    wait_cyc(3);
    chk("bp_single_hs", 128'(hs_cnt - hs_before), 128'd1);

    // Valid gap on the data port after two words; key must not interleave.
    push_exp(mkblk(dw(5, 0), dw(5, 1), dw(5, 2), dw(5, 3)), 1'b0);
    send(1'b0, dw(5, 0));
    send(1'b0, dw(5, 1));
    key_valid = 1'b1; key_word = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap_key_ready", {127'd0, key_ready}, 128'd0);
      chk("gap_busy", {127'd0, busy}, 128'd1);
      chk("gap_partial", {64'd0, blk_data[63:0]}, {64'd0, dw(5, 0), dw(5, 1)});
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
    send(1'b0, dw(5, 2));
    send(1'b0, dw(5, 3));
    wait_cyc(2);

    // Reset after two accepted words discards the partial block.
    send(1'b1, kw(7, 0));
    send(1'b1, kw(7, 1));
    rst = 1'b1; key_valid = 1'b1; data_valid = 1'b1;
    #2;
    chk("mid_rst_blk_data", blk_data, 128'd0);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_blk_valid", {127'd0, blk_valid}, 128'd0);
    chk("mid_rst_readies", {126'd0, key_ready, data_ready}, 128'd0);
    key_valid = 1'b0; data_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(mkblk(dw(6, 0), dw(6, 1), dw(6, 2), dw(6, 3)), 1'b0);
    for (int i = 0; i < 4; i++) send(1'b0, dw(6, i));
    wait_cyc(2);

    // Both ports streaming: key wins first, then strict alternation at 5 cycles/block.
    hs_cyc.delete();
    for (int j = 0; j < 3; j++) begin
      push_exp(mkblk(kw(j, 0), kw(j, 1), kw(j, 2), kw(j, 3)), 1'b1);
      push_exp(mkblk(dw(j, 0), dw(j, 1), dw(j, 2), dw(j, 3)), 1'b0);
    end
    fork
      begin
        for (int j = 0; j < 3; j++)
          for (int i = 0; i < 4; i++) send(1'b1, kw(j, i));
      end
      begin
        for (int j = 0; j < 3; j++)
          for (int i = 0; i < 4; i++) send(1'b0, dw(j, i));
      end
    join
    wait_cyc(6);
    chk("rr_hs_count", 128'(hs_cyc.size()), 128'd6);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("rr_period", 128'(hs_cyc[i] - hs_cyc[i-1]), 128'd5);

    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
